// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared CPU I/O word width, word type and input-port FSM states
package cpu_io_pkg;
  localparam int DATAWIDTH = 25;
  typedef logic [DATAWIDTH-1:0] io_word_t;
  typedef enum logic [1:0] {IDLE, WAIT, DELIVER} in_state_t;
endpackage

// File: rtl/io_fifo.sv
// io_fifo: circular word buffer with registered occupancy count; no write-to-read bypass
module io_fifo #(
  parameter int DW = cpu_io_pkg::DATAWIDTH,
  parameter int DEPTH = 8,
  parameter int PTRWIDTH = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [DW-1:0]       wdata,
  output logic [DW-1:0]       rdata,
  output logic [PTRWIDTH:0]   count,
  output logic                full,
  output logic                empty
);
  logic [DW-1:0] mem [DEPTH];
  logic [PTRWIDTH-1:0] wptr, rptr;
  logic wr, rd;
  assign full = count == (PTRWIDTH+1)'(DEPTH);
  assign empty = count == '0;
  assign rd = pop && !empty;
  // a pop in the same cycle frees the slot, so a push into a full buffer still lands
  assign wr = push && (!full || rd);
  assign rdata = mem[rptr];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + (PTRWIDTH+1)'(wr) - (PTRWIDTH+1)'(rd);
    end
  always_ff @(posedge clock)
    if (wr) mem[wptr] <= wdata;
endmodule

// File: rtl/cpu_in_port.sv
// cpu_in_port: host-fed FIFO delivering words to the CPU via inReq/inValid handshake
// optional CPU_IN_PORT_OVERFLOW_EN adds a sticky overflow flag for dropped pushes
module cpu_in_port #(
  parameter int DATAWIDTH = cpu_io_pkg::DATAWIDTH,
  parameter int DEPTH = 8,
  parameter int PTRWIDTH = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 hostWrite,
  input  logic [DATAWIDTH-1:0] hostData,
  output logic                 hostFull,
  input  logic                 inReq,
  output logic [DATAWIDTH-1:0] inData,
  output logic                 inValid,
  output logic                 inStall,
  output logic [PTRWIDTH:0]    count
`ifdef CPU_IN_PORT_OVERFLOW_EN
  ,
  output logic                 overflow
`endif
);
  import cpu_io_pkg::*;
  in_state_t state, nxt;
  logic pop, empty;
  logic [DATAWIDTH-1:0] head;
  io_fifo #(.DW(DATAWIDTH), .DEPTH(DEPTH), .PTRWIDTH(PTRWIDTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(hostWrite),
    .pop(pop),
    .wdata(hostData),
    .rdata(head),
    .count(count),
    .full(hostFull),
    .empty(empty)
  );
  // DELIVER accepts a new request just like IDLE; WAIT ignores further requests
  always_comb begin
    pop = !empty && (state == WAIT || inReq);
    nxt = pop ? DELIVER : (state == WAIT || inReq) ? WAIT : IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      inData <= '0;
    end else begin
      state <= nxt;
      if (pop) inData <= head;
    end
  assign inValid = state == DELIVER;
  assign inStall = state == WAIT;
`ifdef CPU_IN_PORT_OVERFLOW_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) overflow <= 1'b0;
    else if (hostWrite && hostFull && !pop) overflow <= 1'b1;
`endif
endmodule

// File: tb/tb_cpu_in_port.sv
// tb_cpu_in_port: directed stimulus with a queue-based reference model checked every cycle
module tb_cpu_in_port;
  import cpu_io_pkg::*;
  logic clock = 1'b0, reset = 1'b1, hostWrite = 1'b0, inReq = 1'b0;
  io_word_t hostData = '0;
  logic hostFull, inValid, inStall;
  io_word_t inData;
  logic [3:0] count;
`ifdef CPU_IN_PORT_OVERFLOW_EN
  logic overflow;
`endif
  int checks = 0, errors = 0;

  cpu_in_port dut (
    .clock(clock),
    .reset(reset),
    .hostWrite(hostWrite),
    .hostData(hostData),
    .hostFull(hostFull),
    .inReq(inReq),
    .inData(inData),
    .inValid(inValid),
    .inStall(inStall),
    .count(count)
`ifdef CPU_IN_PORT_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // reference model: a word queue plus one outstanding-request flag
  io_word_t q[$];
  io_word_t m_data;
  bit pend, m_valid, m_ovf, full_b, dlv;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      pend = 0;
      m_valid = 0;
      m_data = '0;
      m_ovf = 0;
    end else begin
      full_b = q.size() == 8;
      dlv = (pend || inReq) && q.size() > 0;
      pend = (pend || inReq) && !dlv;
      if (dlv) m_data = q.pop_front();
      if (hostWrite) begin
        if (!full_b || dlv) q.push_back(hostData);
        else m_ovf = 1;
      end
      m_valid = dlv;
    end
  end

  always @(negedge clock) begin
    check("m_valid", inValid, m_valid);
    check("m_stall", inStall, pend);
    check("m_data", inData, m_data);
    check("m_count", count, q.size());
    check("m_full", hostFull, q.size() == 8);
`ifdef CPU_IN_PORT_OVERFLOW_EN
    check("m_overflow", overflow, m_ovf);
`endif
  end

  task automatic drive(bit w, io_word_t d, bit r);
    hostWrite = w;
    hostData = d;
    inReq = r;
    @(negedge clock);
    hostWrite = 0;
    inReq = 0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    idle(2);
    check("rst_data", inData, 0);
    check("rst_valid", inValid, 0);
    check("rst_stall", inStall, 0);
    check("rst_count", count, 0);
    check("rst_full", hostFull, 0);
    reset = 0;
    // three words, requests two cycles apart
    drive(1, 25'h1, 0);
    drive(1, 25'h2, 0);
    drive(1, 25'h3, 0);
    idle(2);
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1);
      check("t1_valid", inValid, 1);
      check("t1_data", inData, i + 1);
      idle(1);
      check("t1_valid_drop", inValid, 0);
    end
    check("t1_count", count, 0);
    // request on empty FIFO, then late push
    drive(0, '0, 1);
    check("t2_stall", inStall, 1);
    idle(2);
    check("t2_stall_hold", inStall, 1);
    drive(1, 25'h1ABCDEF, 0);
    check("t2_nobypass", inValid, 0);
    idle(1);
    check("t2_valid", inValid, 1);
    check("t2_data", inData, 25'h1ABCDEF);
    check("t2_stall_off", inStall, 0);
    // overfill by one
    for (int i = 0; i < 9; i++) begin
      drive(1, 25'h10 + 25'(i), 0);
      if (i == 7) check("t3_full", hostFull, 1);
    end
    check("t3_count", count, 8);
`ifdef CPU_IN_PORT_OVERFLOW_EN
    check("t3_ovf", overflow, 1);
`endif
    for (int i = 0; i < 8; i++) begin
      drive(0, '0, 1);
      check("t3_data", inData, 32'h10 + 32'(i));
      idle(1);
    end
    check("t3_empty", count, 0);
`ifdef CPU_IN_PORT_OVERFLOW_EN
    check("t3_ovf_sticky", overflow, 1);
`endif
    // push into a full FIFO together with a pop
    for (int i = 0; i < 8; i++) drive(1, 25'h20 + 25'(i), 0);
    drive(1, 25'h0FFFFFF, 1);
    check("t4_count", count, 8);
    check("t4_data0", inData, 32'h20);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      drive(0, '0, 1);
      check("t4_data", inData, i < 7 ? 32'h21 + 32'(i) : 32'h0FFFFFF);
      idle(1);
    end
    // asynchronous reset while delivering
    drive(1, 25'h55, 0);
    idle(1);
    drive(0, '0, 1);
    check("t5_valid", inValid, 1);
    check("t5_data", inData, 32'h55);
    #2 reset = 1;
    #1;
    check("t5_rst_valid", inValid, 0);
    check("t5_rst_data", inData, 0);
    check("t5_rst_count", count, 0);
`ifdef CPU_IN_PORT_OVERFLOW_EN
    check("t5_rst_ovf", overflow, 0);
`endif
    @(negedge clock);
    reset = 0;
    drive(0, '0, 1);
    check("t5_wait", inStall, 1);
    drive(1, 25'h77, 0);
    idle(1);
    check("t5_late_data", inData, 32'h77);
    // pointer wrap-around
    for (int i = 0; i < 20; i++) begin
      drive(1, 25'(i), 0);
      drive(0, '0, 1);
      check("t6_valid", inValid, 1);
      check("t6_data", inData, i);
    end
    idle(1);
    check("t6_count", count, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
